addsub_serial: RTL and testbench

Parametrised, multi-cycle signed/unsigned add/subtract unit that processes a WIDTH-bit operation DIGIT bits per clock, LSB digit first. Carries ripple between digits through a registered carry. It generalises the combinational 32-bit ripple add/sub with:
- configurable width and digit size,
- optional signed saturation,
- zero and negative flags,
- valid/ready handshakes on input and output.

It sits between an operand source and a result consumer in datapaths where area matters more than single-cycle latency.

---
 rtl/addsub_serial_if.sv | 28 ++
 rtl/addsub_serial.sv | 162 ++++++++++++++++
 tb/tb_addsub_serial.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_if.sv
// Handshake bundle for the digit-serial add/sub unit.
// Operand side and result side, each with its own valid/ready pair.
interface addsub_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             cout;
  logic             V;
  logic             Z;
  logic             Nf;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, ans, cout, V, Z, Nf
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, ans, cout, V, Z, Nf
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial signed/unsigned add/subtract, LSB digit first.
// Optional signed saturation; registered carry between digits.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_serial_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             carry_q, carry_d;
  logic             sat_q, sat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             nf_q, nf_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] sum_dig;
  logic             c_out;
  logic             c_top;
  logic [WIDTH-1:0] ans_w;
  logic             last;
  logic             accept;
  logic             ovf;

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.ans       = ans_q;
  assign bus.cout      = cout_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;
  assign bus.Nf        = nf_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt_q == CW'(N - 1));
  assign ovf    = c_top ^ c_out;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    ans_w = ans_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        b_dig = bx_q[k*DIGIT +: DIGIT];
        ans_w[k*DIGIT +: DIGIT] = sum_dig;
      end
    end
  end

  // c_top keeps the carry into the digit MSB for the overflow flag
  always_comb begin
    logic c;
    c       = carry_q;
    c_top   = carry_q;
    sum_dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_top = c;
      sum_dig[i] = a_dig[i] ^ b_dig[i] ^ c;
      c = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
    end
    c_out = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    carry_d = carry_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    ans_d   = ans_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    nf_d    = nf_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          a_d     = bus.A;
          bx_d    = bus.B ^ {WIDTH{bus.op[0]}};
          carry_d = bus.op[0];
          sat_d   = bus.op[1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        ans_d   = ans_w;
        carry_d = c_out;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cout_d = c_out;
          v_d    = ovf;
          if (sat_q && ovf) begin
            ans_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
          end
          z_d     = (ans_d == '0);
          nf_d    = ans_d[WIDTH-1];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      ans_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      ans_q   <= ans_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
      nf_q    <= nf_d;
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: DIGIT=8 and DIGIT=WIDTH instances,
// directed table, hand sequences and random ops vs. an integer model.
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic        ordy;
  logic        sel;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [1:0]  op_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(32)) b8 ();
  addsub_serial_if #(.WIDTH(32)) b32 ();

  assign b8.in_valid   = iv & ~sel;
  assign b32.in_valid  = iv & sel;
  assign b8.A          = a_s;
  assign b32.A         = a_s;
  assign b8.B          = b_s;
  assign b32.B         = b_s;
  assign b8.op         = op_s;
  assign b32.op        = op_s;
  assign b8.out_ready  = ordy;
  assign b32.out_ready = ordy;

  addsub_serial #(.WIDTH(32), .DIGIT(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  addsub_serial #(.WIDTH(32), .DIGIT(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  logic        ov, ir, co, vf, zf, nf;
  logic [31:0] an;
  assign ov = sel ? b32.out_valid : b8.out_valid;
  assign ir = sel ? b32.in_ready  : b8.in_ready;
  assign an = sel ? b32.ans       : b8.ans;
  assign co = sel ? b32.cout      : b8.cout;
  assign vf = sel ? b32.V         : b8.V;
  assign zf = sel ? b32.Z         : b8.Z;
  assign nf = sel ? b32.Nf        : b8.Nf;

  typedef struct {
    logic [31:0] ans;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    res_t        exp;
  } vec_t;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] o);
    res_t r;
    longint sa, sb, s;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    s  = o[0] ? sa - sb : sa + sb;
    r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.c = o[0] ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
    r.ans = s[31:0];
    if (o[1] && r.v) r.ans = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    r.z = (r.ans == 32'h0);
    r.n = r.ans[31];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".ans"}, an, e.ans);
    chk({tag, ".cout"}, co, e.c);
    chk({tag, ".V"}, vf, e.v);
    chk({tag, ".Z"}, zf, e.z);
    chk({tag, ".Nf"}, nf, e.n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, ov, 0);
    chk({tag, ".ans"}, an, 0);
    chk({tag, ".flags"}, {co, vf, zf, nf}, 0);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] o);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", ir, 1);
    a_s  = a;
    b_s  = b;
    op_s = o;
    iv   = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ov && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("out_valid_seen", ov, 1);
  endtask

  task automatic finish_hs(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid_drop"}, ov, 0);
    chk({tag, ".in_ready_back"}, ir, 1);
  endtask

  task automatic run_full(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] o,
                          input res_t e, input int exp_lat);
    int lat;
    start_op(a, b, o);
    wait_out(lat);
    chk({tag, ".latency"}, lat, exp_lat);
    chk_res(tag, e);
    finish_hs(tag);
  endtask

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    res_t e;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    tbl[0] = '{32'h0000_0021, 32'h0000_0022, 2'b00, '{32'h0000_0043, 0, 0, 0, 0}};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, '{32'h8000_0000, 0, 1, 0, 1}};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b10, '{32'h7FFF_FFFF, 0, 1, 0, 0}};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 2'b01, '{32'h7FFF_FFFF, 1, 1, 0, 0}};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 2'b11, '{32'h8000_0000, 1, 1, 0, 1}};
    tbl[5] = '{32'h336F_B7E5, 32'h336F_B7E5, 2'b01, '{32'h0000_0000, 1, 0, 1, 0}};
    tbl[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 2'b01, '{32'hFFFF_FFFF, 0, 1, 0, 1}};
    tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, '{32'h0000_0000, 1, 0, 1, 0}};

    rst_n = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b1;
    sel   = 1'b0;
    a_s   = '0;
    b_s   = '0;
    op_s  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready8", b8.in_ready, 0);
    chk("reset.in_ready32", b32.in_ready, 0);
    chk_zero("reset8");
    chk("reset32.out_valid", b32.out_valid, 0);
    chk("reset32.ans", b32.ans, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset.in_ready", ir, 1);

    for (int i = 0; i < 8; i++)
      run_full($sformatf("tbl8_%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
               tbl[i].exp, 4);

    // backpressure with junk on the operand side
    @(negedge clk);
    ordy = 1'b0;
    e = model(32'h1234_5678, 32'h8765_4321, 2'b01);
    start_op(32'h1234_5678, 32'h8765_4321, 2'b01);
    wait_out(lat);
    chk("bp.latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv  = ~iv;
      a_s = $urandom;
      b_s = $urandom;
      op_s = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.out_valid", i), ov, 1);
      chk($sformatf("bp%0d.in_ready", i), ir, 0);
      chk_res($sformatf("bp%0d", i), e);
    end
    @(negedge clk);
    iv   = 1'b0;
    ordy = 1'b1;
    finish_hs("bp_release");

    // reset during the second RUN cycle
    start_op(32'h1111_1111, 32'h2222_2222, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrun_rst8");
    chk("midrun_rst8.in_ready", ir, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrun_rst8.in_ready_after", ir, 1);
    repeat (6) @(posedge clk);
    #1 chk("midrun_rst8.no_partial", ov, 0);
    e = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b00);
    run_full("after_rst8", 32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b00, e, 4);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      ro = 2'($urandom_range(0, 3));
      e  = model(ra, rb, ro);
      run_full($sformatf("rnd8_%0d", i), ra, rb, ro, e, 4);
    end

    // single-digit instance
    @(negedge clk);
    sel = 1'b1;
    for (int i = 0; i < 8; i++)
      run_full($sformatf("tbl32_%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
               tbl[i].exp, 1);

    start_op(32'h4444_4444, 32'h1111_1111, 2'b01);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrun_rst32");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("midrun_rst32.no_partial", ov, 0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ 32'h8000_0000) : $urandom;
      ro = 2'($urandom_range(0, 3));
      e  = model(ra, rb, ro);
      run_full($sformatf("rnd32_%0d", i), ra, rb, ro, e, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
